// File: rtl/adder_bist_pkg.sv
// Shared types and defaults for the adder self-test controller.
// The delay-line entry carries the expected {carry,sum} next to its vector index.
package adder_bist_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LAT_MAX    = 7;
  localparam int CNT_W_DEF  = 16;
  localparam int DRAIN_W    = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [CNT_W_DEF-1:0]  idx;
    logic [DATA_W_DEF:0]   exp;
  } exp_entry_t;

endpackage

// File: rtl/adder_bist_pipe.sv
// LAT-deep delay line of expected results, aligned with the adder's own latency.
// With LAT=0 the entry is compared in the same cycle, so it is a plain wire.
module adder_bist_pipe
  import adder_bist_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  exp_entry_t in_entry,
  output exp_entry_t out_entry
);

  if (LAT == 0) begin : g_pass
    assign out_entry = in_entry;
  end else begin : g_shift
    exp_entry_t stage_q [LAT];
    exp_entry_t stage_d [LAT];

    always_comb begin
      stage_d[0] = in_entry;
      for (int i = 1; i < LAT; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < LAT; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < LAT; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign out_entry = stage_q[LAT-1];
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// Self-test driver and checker for the 8-bit adder: walks idx over {b,a},
// compares the delayed adder response to a+b and reports pass/err_cnt/first_err_idx.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_vec,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] sum,
  input  logic              carry,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_vec_q, n_vec_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   first_q, first_d;

  exp_entry_t push_entry;
  exp_entry_t pop_entry;
  logic       mismatch;
  logic       finish;

  // Only DRIVE cycles push real vectors; DRAIN pushes bubbles to flush the line.
  always_comb begin
    push_entry.valid = (state_q == DRIVE);
    push_entry.idx   = idx_q;
    push_entry.exp   = {1'b0, a_q} + {1'b0, b_q};
  end

  adder_bist_pipe #(
    .LAT(LAT)
  ) u_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .in_entry (push_entry),
    .out_entry(pop_entry)
  );

  assign mismatch = pop_entry.valid && ({carry, sum} != pop_entry.exp);

  always_comb begin
    state_d   = state_q;
    n_vec_d   = n_vec_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    a_d       = a_q;
    b_d       = b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    finish    = 1'b0;

    if (mismatch) begin
      err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
      if (err_cnt_q == '0) begin
        first_d = pop_entry.idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_vec_d   = n_vec;
          err_cnt_d = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          if (n_vec == '0) begin
            finish = 1'b1;
          end else begin
            state_d = DRIVE;
            busy_d  = 1'b1;
            idx_d   = '0;
            a_d     = '0;
            b_d     = '0;
          end
        end
      end
      DRIVE: begin
        if (idx_q == n_vec_q - 1'b1) begin
          if (LAT > 0) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            finish = 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          a_d   = idx_d[DATA_W-1:0];
          b_d   = idx_d[2*DATA_W-1:DATA_W];
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(LAT - 1)) begin
          finish = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The last vector is checked on the same edge that leaves the run, so
    // pass has to look at the updated error count.
    if (finish) begin
      state_d = DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      n_vec_q   <= '0;
      idx_q     <= '0;
      drain_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      n_vec_q   <= n_vec_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
    end
  end

  assign a             = a_q;
  assign b             = b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: three instances (LAT 0, 1, 3) each facing a
// behavioural adder with selectable faults, checked against a vector-level model.
module tb_adder_bist_ctrl;

  logic        clk;
  logic        rstn;
  logic        start_v   [3];
  logic [15:0] n_vec_v   [3];
  logic [7:0]  a_o       [3];
  logic [7:0]  b_o       [3];
  logic [7:0]  sum_v     [3];
  logic        carry_v   [3];
  logic        busy_o    [3];
  logic        done_o    [3];
  logic        pass_o    [3];
  logic [15:0] err_o     [3];
  logic [15:0] first_o   [3];

  int  fault_mode;
  bit  bad [65536];
  int  errors;
  int  checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder response for a given fault mode: 0 good, 1 carry stuck at 0,
  // 2 sum bit0 inverted, 3 sum bit0 flipped on a random set of {b,a} inputs.
  function automatic logic [8:0] faulty(input logic [7:0] fa, input logic [7:0] fb, input int mode);
    logic [8:0] s;
    s = {1'b0, fa} + {1'b0, fb};
    case (mode)
      1: s[8] = 1'b0;
      2: s[0] = ~s[0];
      3: if (bad[{fb, fa}]) s[0] = ~s[0];
      default: ;
    endcase
    return s;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    adder_bist_ctrl #(
      .DATA_W(8),
      .LAT   (L),
      .CNT_W (16)
    ) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start_v[g]),
      .n_vec        (n_vec_v[g]),
      .a            (a_o[g]),
      .b            (b_o[g]),
      .sum          (sum_v[g]),
      .carry        (carry_v[g]),
      .busy         (busy_o[g]),
      .done         (done_o[g]),
      .pass         (pass_o[g]),
      .err_cnt      (err_o[g]),
      .first_err_idx(first_o[g])
    );

    if (L == 0) begin : g_comb
      assign {carry_v[g], sum_v[g]} = faulty(a_o[g], b_o[g], fault_mode);
    end else begin : g_reg
      logic [8:0] st [L];
      always @(posedge clk) begin
        st[0] <= faulty(a_o[g], b_o[g], fault_mode);
        for (int i = 1; i < L; i++) st[i] <= st[i-1];
      end
      assign {carry_v[g], sum_v[g]} = st[L-1];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one vector sweep on instance g and compares everything observable
  // against what the run should look like from the vector list alone.
  task automatic applyStimulus(input int g, input int n, input int mode, input bit spam);
    int lat, k, busy_cycles, done_cnt, done_at, seq_bad, quiet_bad, exp_err, exp_first, exp_busy;
    logic [15:0] jv, iv;
    lat = lat_of(g);
    busy_cycles = 0; done_cnt = 0; done_at = -1; seq_bad = 0; quiet_bad = 0;
    exp_err = 0; exp_first = 0;
    fault_mode = mode;

    for (int i = 0; i < n; i++) begin
      iv = 16'(i);
      if (faulty(iv[7:0], iv[15:8], mode) != ({1'b0, iv[7:0]} + {1'b0, iv[15:8]})) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
    end
    if (exp_err > 65535) exp_err = 65535;
    exp_busy = (n == 0) ? 0 : n + lat;

    @(negedge clk);
    start_v[g] = 1'b1;
    n_vec_v[g] = 16'(n);
    @(negedge clk);
    start_v[g] = 1'b0;
    n_vec_v[g] = 16'($urandom);

    k = 1;
    while (done_cnt == 0 && k < n + lat + 20) begin
      if (busy_o[g]) begin
        busy_cycles++;
        jv = (k <= n) ? 16'(k - 1) : 16'(n - 1);
        if (a_o[g] !== jv[7:0] || b_o[g] !== jv[15:8]) seq_bad++;
      end
      if (done_o[g]) begin
        done_cnt++;
        done_at = k;
      end
      start_v[g] = spam && (k == 1 || done_o[g]);
      @(negedge clk);
      k++;
    end
    start_v[g] = 1'b0;

    checkOutput($sformatf("g%0d_n%0d_done_at", g, n), 32'(done_at), 32'(exp_busy + 1));
    checkOutput($sformatf("g%0d_n%0d_busy_cycles", g, n), 32'(busy_cycles), 32'(exp_busy));
    checkOutput($sformatf("g%0d_n%0d_ab_seq_bad", g, n), 32'(seq_bad), 32'd0);
    checkOutput($sformatf("g%0d_n%0d_pass", g, n), {31'd0, pass_o[g]}, {31'd0, exp_err == 0});
    checkOutput($sformatf("g%0d_n%0d_err_cnt", g, n), {16'd0, err_o[g]}, 32'(exp_err));
    checkOutput($sformatf("g%0d_n%0d_first_err", g, n), {16'd0, first_o[g]}, 32'(exp_first));

    for (int i = 0; i < 3; i++) begin
      if (busy_o[g] || done_o[g]) quiet_bad++;
      @(negedge clk);
    end
    checkOutput($sformatf("g%0d_n%0d_quiet_after", g, n), 32'(quiet_bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dpulses;
    errors = 0;
    checks = 0;
    fault_mode = 0;
    rstn = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      n_vec_v[g] = '0;
    end

    #3;
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("rst%0d_ctl", g), {11'd0, a_o[g], b_o[g], busy_o[g], done_o[g], pass_o[g]}, 32'd0);
      checkOutput($sformatf("rst%0d_err", g), {err_o[g], first_o[g]}, 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    applyStimulus(1, 4, 0, 1'b0);
    applyStimulus(1, 65535, 0, 1'b0);
    applyStimulus(1, 512, 1, 1'b0);
    applyStimulus(0, 3, 2, 1'b0);
    applyStimulus(1, 0, 0, 1'b0);
    applyStimulus(0, 0, 0, 1'b0);
    applyStimulus(2, 600, 1, 1'b0);
    applyStimulus(2, 5, 2, 1'b0);

    // Reset in the middle of a long run, then a short run with stray starts.
    fault_mode = 0;
    dpulses = 0;
    @(negedge clk);
    start_v[1] = 1'b1;
    n_vec_v[1] = 16'd100;
    @(negedge clk);
    start_v[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done_o[1]) dpulses++;
      @(negedge clk);
    end
    checkOutput("mid_run_busy", {31'd0, busy_o[1]}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_ctl", {11'd0, a_o[1], b_o[1], busy_o[1], done_o[1], pass_o[1]}, 32'd0);
    checkOutput("async_rst_err", {err_o[1], first_o[1]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_o[1]) dpulses++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_o[1] || busy_o[1]) dpulses++;
    end
    checkOutput("no_done_after_reset", 32'(dpulses), 32'd0);
    applyStimulus(1, 2, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      int g, n;
      for (int i = 0; i < 1024; i++) bad[i] = ($urandom_range(0, 15) == 0);
      g = $urandom_range(0, 2);
      n = $urandom_range(1, 400);
      applyStimulus(g, n, 3, r[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
